// File: rtl/rdmx_encoder.sv
// rdmx_encoder -- transmit-side RDMX framer.
//
// Accepts a command (PCI target address plus payload length) and emits one
// packet on a 512-bit AXI-Stream. The first beat is a 64-byte header
// (Ethernet 14 B, IPv4 20 B, UDP 8 B, RDMX 22 B). The remaining beats are
// ceil(bytes/64) payload beats passed straight through from the payload
// stream, and the last of those beats carries a trimmed tkeep.
//
// Optional feature, selected by the macro RDMX_IP_CSUM_EN:
//   defined   -> BUILD is a 3-cycle pipeline that computes the IPv4 header
//                checksum (sum, fold twice, invert).
//   undefined -> ip_checksum is 16'h0000 and BUILD takes a single cycle.
//
// Ports:
//   clk, resetn           clock, asynchronous active-low reset
//   cmd_addr/cmd_bytes    command: target address and payload length
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   pay_tdata/tvalid/tready  payload stream in (byte 0 in bits [7:0])
//   out_tdata/tkeep/tlast/tvalid/tready  TX stream toward the MAC
//   cmd_error             one-cycle pulse when a command exceeds MAX_PAYLOAD
//   pkt_count             packets fully transmitted (wraps at 2^32)
module rdmx_encoder #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0200_0000_0001,
    parameter logic [31:0] SRC_IP      = 32'h0A00_0001,
    parameter logic [31:0] DST_IP      = 32'h0A00_0002,
    parameter logic [15:0] SRC_PORT    = 16'd32002,
    parameter logic [15:0] DST_PORT    = 16'd32002,
    parameter logic [15:0] RDMX_MAGIC  = 16'h0122,
    parameter logic [15:0] MAX_PAYLOAD = 16'd16320
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [63:0]  cmd_addr,
    input  logic [15:0]  cmd_bytes,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [511:0] pay_tdata,
    input  logic         pay_tvalid,
    output logic         pay_tready,
    output logic [511:0] out_tdata,
    output logic [63:0]  out_tkeep,
    output logic         out_tlast,
    output logic         out_tvalid,
    input  logic         out_tready,
    output logic         cmd_error,
    output logic [31:0]  pkt_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUILD   = 2'd1,
        ST_HDR     = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    state_t         state_r;
    logic [63:0]    addr_r;
    logic [15:0]    bytes_r;
    logic [7:0]     cnt_r;          // payload beats still to send
    logic [63:0]    keep_last_r;    // tkeep for the final payload beat
    logic [511:0]   hdr_data_r;
    logic [63:0]    hdr_keep_r;
    logic           hdr_valid_r;
    logic           hdr_last_r;
    logic           cmd_ready_r;
    logic           cmd_error_r;
    logic [31:0]    pkt_count_r;

    logic [15:0]    ip_len_s;
    logic [15:0]    udp_len_s;
    logic [5:0]     rem_s;
    logic [7:0]     cycles_s;
    logic [63:0]    keep_last_s;
    logic [15:0]    hdr_csum_s;
    logic           build_done_s;
    logic           final_beat_s;
    logic           out_hs_s;

    // Reverse byte order so big-endian header byte 0 lands in bits [7:0].
    function automatic logic [511:0] byte_swap(input logic [511:0] be);
        logic [511:0] le;
        le = 512'd0;
        for (int i = 0; i < 64; i++) begin
            le[8*i +: 8] = be[511-8*i -: 8];
        end
        return le;
    endfunction

    // Header in wire order (big-endian), then swapped for the little-endian bus.
    function automatic logic [511:0] build_header(input logic [63:0] addr,
                                                  input logic [15:0] ip_len,
                                                  input logic [15:0] udp_len,
                                                  input logic [15:0] csum);
        return byte_swap({DST_MAC, SRC_MAC, 16'h0800,
                          16'h4500, ip_len, 16'h0000, 16'h4000, 16'h4011, csum,
                          SRC_IP, DST_IP,
                          SRC_PORT, DST_PORT, udp_len, 16'h0000,
                          RDMX_MAGIC, addr, 96'h0});
    endfunction

`ifdef RDMX_IP_CSUM_EN
    logic [1:0]  build_stage_r;
    logic [19:0] csum_sum_r;
    logic [15:0] csum_fold_r;

    // Sum of the ten IPv4 header words with the checksum word taken as zero.
    function automatic logic [19:0] ip_sum20(input logic [15:0] ip_len);
        return 20'h04500 + {4'd0, ip_len} + 20'h00000 + 20'h04000 + 20'h04011 +
               {4'd0, SRC_IP[31:16]} + {4'd0, SRC_IP[15:0]} +
               {4'd0, DST_IP[31:16]} + {4'd0, DST_IP[15:0]};
    endfunction

    // Two end-around carry folds; the second can never carry out again.
    function automatic logic [15:0] ip_fold(input logic [19:0] s);
        logic [16:0] f1;
        f1 = {1'b0, s[15:0]} + {13'd0, s[19:16]};
        return f1[15:0] + {15'd0, f1[16]};
    endfunction

    // Checksum pipeline: stage 0 sums, stage 1 folds, stage 2 hands off to the header load.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            build_stage_r <= 2'd0;
            csum_sum_r    <= 20'd0;
            csum_fold_r   <= 16'd0;
        end else if (state_r == ST_BUILD) begin
            case (build_stage_r)
                2'd0: begin
                    csum_sum_r    <= ip_sum20(ip_len_s);
                    build_stage_r <= 2'd1;
                end
                2'd1: begin
                    csum_fold_r   <= ip_fold(csum_sum_r);
                    build_stage_r <= 2'd2;
                end
                default: begin
                    build_stage_r <= 2'd0;
                end
            endcase
        end else begin
            build_stage_r <= 2'd0;
        end
    end

    assign build_done_s = (build_stage_r == 2'd2);
    assign hdr_csum_s   = ~csum_fold_r;
`else
    assign build_done_s = 1'b1;
    assign hdr_csum_s   = 16'h0000;
`endif

    // Length fields, beat count and last-beat byte mask derived from the latched length.
    always_comb begin
        ip_len_s  = bytes_r + 16'd50;
        udp_len_s = bytes_r + 16'd30;
        rem_s     = bytes_r[5:0];
        // bytes_r never exceeds 16320, so bits [13:6] hold the whole-beat count.
        cycles_s  = bytes_r[13:6] + {7'd0, |rem_s};
        if (rem_s == 6'd0) begin
            keep_last_s = {64{1'b1}};
        end else begin
            keep_last_s = (64'd1 << rem_s) - 64'd1;
        end
    end

    assign final_beat_s = (cnt_r == 8'd1);

    // Output mux: header registers outside PAYLOAD, direct pass-through inside it.
    always_comb begin
        if (state_r == ST_PAYLOAD) begin
            out_tdata  = pay_tdata;
            out_tvalid = pay_tvalid;
            pay_tready = out_tready;
            out_tlast  = final_beat_s;
            out_tkeep  = final_beat_s ? keep_last_r : {64{1'b1}};
        end else begin
            out_tdata  = hdr_data_r;
            out_tvalid = hdr_valid_r;
            pay_tready = 1'b0;
            out_tlast  = hdr_last_r;
            out_tkeep  = hdr_keep_r;
        end
    end

    assign out_hs_s  = out_tvalid && out_tready;
    assign cmd_ready = cmd_ready_r;
    assign cmd_error = cmd_error_r;
    assign pkt_count = pkt_count_r;

    // Main control FSM: command intake, header load, header beat, payload beat counting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            addr_r      <= 64'd0;
            bytes_r     <= 16'd0;
            cnt_r       <= 8'd0;
            keep_last_r <= 64'd0;
            hdr_data_r  <= 512'd0;
            hdr_keep_r  <= 64'd0;
            hdr_valid_r <= 1'b0;
            hdr_last_r  <= 1'b0;
            cmd_ready_r <= 1'b0;
            cmd_error_r <= 1'b0;
            pkt_count_r <= 32'd0;
        end else begin
            cmd_error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cmd_ready_r <= 1'b1;
                    if (cmd_valid && cmd_ready_r) begin
                        if (cmd_bytes > MAX_PAYLOAD) begin
                            cmd_error_r <= 1'b1;
                        end else begin
                            addr_r      <= cmd_addr;
                            bytes_r     <= cmd_bytes;
                            cmd_ready_r <= 1'b0;
                            state_r     <= ST_BUILD;
                        end
                    end
                end
                ST_BUILD: begin
                    if (build_done_s) begin
                        hdr_data_r  <= build_header(addr_r, ip_len_s, udp_len_s, hdr_csum_s);
                        hdr_keep_r  <= {64{1'b1}};
                        hdr_valid_r <= 1'b1;
                        hdr_last_r  <= (cycles_s == 8'd0);
                        cnt_r       <= cycles_s;
                        keep_last_r <= keep_last_s;
                        state_r     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (out_tready) begin
                        // Clear the header registers so idle outputs read as zero.
                        hdr_data_r  <= 512'd0;
                        hdr_keep_r  <= 64'd0;
                        hdr_valid_r <= 1'b0;
                        hdr_last_r  <= 1'b0;
                        if (cnt_r == 8'd0) begin
                            pkt_count_r <= pkt_count_r + 32'd1;
                            cmd_ready_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            state_r     <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (out_hs_s) begin
                        cnt_r <= cnt_r - 8'd1;
                        if (final_beat_s) begin
                            pkt_count_r <= pkt_count_r + 32'd1;
                            cmd_ready_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
